// File: rtl/joy_sega6_reader.sv
// Sega Mega Drive / Master System DB9 pad reader for two ports.
// A shared select line is toggled through an 8-step sequence every 256 ticks; each port is decoded independently.

module joy_sega6_port (
    input  logic        clk_i,
    input  logic        res_n_i,
    input  logic        tick_i,
    input  logic [7:0]  step_i,
    input  logic [5:0]  pins_i,   // {p9, p6, R, L, D, U}, synchronized, active-low
    output logic [11:0] joy_o,
    output logic        six_o
);
    logic [11:0] sh_q, sh_d, joy_q, joy_d;
    logic        six_sh_q, six_sh_d, six_q, six_d;

    always_comb begin
        sh_d     = sh_q;
        six_sh_d = six_sh_q;
        joy_d    = joy_q;
        six_d    = six_q;
        if (tick_i) begin
            case (step_i)
                8'd2: begin
                    sh_d[5:0] = pins_i;
                    six_sh_d  = 1'b0;
                end
                // L and R both low with select low identifies a Mega Drive pad.
                8'd3: sh_d[7:6] = (pins_i[3:2] == 2'b00) ? pins_i[5:4] : 2'b11;
                8'd5: if (pins_i[3:0] == 4'h0) six_sh_d = 1'b1;
                8'd6: sh_d[11:8] = six_sh_q ? pins_i[3:0] : 4'hF;
                8'd7: begin
                    joy_d = sh_q;
                    six_d = six_sh_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            sh_q     <= 12'hFFF;
            six_sh_q <= 1'b0;
            joy_q    <= 12'hFFF;
            six_q    <= 1'b0;
        end else begin
            sh_q     <= sh_d;
            six_sh_q <= six_sh_d;
            joy_q    <= joy_d;
            six_q    <= six_d;
        end
    end

    assign joy_o = joy_q;
    assign six_o = six_q;
endmodule

module joy_sega6_reader #(
    parameter int DIV = 704
) (
    input  logic        clk_i,
    input  logic        res_n_i,
    input  logic        joy1_up_i,
    input  logic        joy1_down_i,
    input  logic        joy1_left_i,
    input  logic        joy1_right_i,
    input  logic        joy1_p6_i,
    input  logic        joy1_p9_i,
    input  logic        joy2_up_i,
    input  logic        joy2_down_i,
    input  logic        joy2_left_i,
    input  logic        joy2_right_i,
    input  logic        joy2_p6_i,
    input  logic        joy2_p9_i,
    output logic        joyX_p7_o,
    output logic [11:0] joy1_o,
    output logic [11:0] joy2_o,
    output logic        six1_o,
    output logic        six2_o,
    output logic        upd_o
);
    localparam int NUM_PORTS = 2;
    localparam int CW        = 16;

    logic [NUM_PORTS-1:0][5:0]  raw, sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NUM_PORTS-1:0][11:0] joy;
    logic [NUM_PORTS-1:0]       six;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [7:0]                 s_q, s_d;
    logic                       p7_q, p7_d, upd_q, upd_d, tick;

    assign raw[0] = {joy1_p9_i, joy1_p6_i, joy1_right_i, joy1_left_i, joy1_down_i, joy1_up_i};
    assign raw[1] = {joy2_p9_i, joy2_p6_i, joy2_right_i, joy2_left_i, joy2_down_i, joy2_up_i};

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        tick    = (cnt_q == CW'(DIV - 1));
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        s_d     = tick ? s_q + 8'd1 : s_q;
        p7_d    = p7_q;
        // Select alternates low/high over steps 0..7, then idles high so 6-button pads time out.
        if (tick) p7_d = (s_q < 8'd8) ? s_q[0] : 1'b1;
        upd_d   = tick && (s_q == 8'd7);
    end

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            sync1_q <= '1;
            sync2_q <= '1;
            cnt_q   <= '0;
            s_q     <= 8'd0;
            p7_q    <= 1'b1;
            upd_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            p7_q    <= p7_d;
            upd_q   <= upd_d;
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        joy_sega6_port u_port (
            .clk_i  (clk_i),
            .res_n_i(res_n_i),
            .tick_i (tick),
            .step_i (s_q),
            .pins_i (sync2_q[g]),
            .joy_o  (joy[g]),
            .six_o  (six[g])
        );
    end

    assign joyX_p7_o = p7_q;
    assign upd_o     = upd_q;
    assign joy1_o    = joy[0];
    assign joy2_o    = joy[1];
    assign six1_o    = six[0];
    assign six2_o    = six[1];
endmodule

// File: tb/tb_joy_sega6_reader.sv
// Bench for joy_sega6_reader: behavioural pad models on both ports and a per-cycle
// reference model of select waveform, commit timing and decoded button words.

module tb_joy_sega6_reader;
    localparam int DIV = 4;
    localparam int P   = 256 * DIV;
    localparam int T_MD3 = 0, T_MD6 = 1, T_SMS = 2;

    logic clk = 1'b0, rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [5:0]  pin1, pin2;           // {p9, p6, R, L, D, U}, active-low
    logic        p7, six1, six2, upd;
    logic [11:0] joy1, joy2;

    joy_sega6_reader #(.DIV(DIV)) dut (
        .clk_i(clk), .res_n_i(rst_n),
        .joy1_up_i(pin1[0]), .joy1_down_i(pin1[1]), .joy1_left_i(pin1[2]),
        .joy1_right_i(pin1[3]), .joy1_p6_i(pin1[4]), .joy1_p9_i(pin1[5]),
        .joy2_up_i(pin2[0]), .joy2_down_i(pin2[1]), .joy2_left_i(pin2[2]),
        .joy2_right_i(pin2[3]), .joy2_p6_i(pin2[4]), .joy2_p9_i(pin2[5]),
        .joyX_p7_o(p7), .joy1_o(joy1), .joy2_o(joy2),
        .six1_o(six1), .six2_o(six2), .upd_o(upd)
    );

    // Pad state: type and pressed buttons (active-high, order M X Y Z S A C B R L D U).
    int          typ [2];
    logic [11:0] btn [2];
    bit          raw_mode;
    logic [5:0]  raw [2];
    int          lows = 0;
    int          idle = 1000000;

    // A 6-button pad counts select falls and forgets the count after a long high idle.
    initial forever begin
        @(posedge clk);
        idle = p7 ? idle + 1 : 0;
    end
    initial forever begin
        @(negedge p7);
        lows = (idle >= 16 * DIV) ? 1 : lows + 1;
    end

    function automatic logic [5:0] pad_pins(int t, logic [11:0] b, logic sel, int nl);
        logic [5:0] pr;
        if (t == T_SMS)            pr = {b[5], b[4], b[3:0]};
        else if (sel && t == T_MD6 && nl == 3) pr = {b[5], b[4], b[11:8]};
        else if (sel)              pr = {b[5], b[4], b[3:0]};
        else if (t == T_MD6 && nl == 3) pr = {b[7], b[6], 4'b1111};
        else                       pr = {b[7], b[6], 2'b11, b[1:0]};
        return ~pr;
    endfunction

    always_comb begin
        pin1 = raw_mode ? raw[0] : pad_pins(typ[0], btn[0], p7, lows);
        pin2 = raw_mode ? raw[1] : pad_pins(typ[1], btn[1], p7, lows);
    end

    function automatic logic [11:0] exp_word(int t, logic [11:0] b);
        if (t == T_MD6)      return ~b;
        else if (t == T_MD3) return ~{4'h0, b[7:0]};
        else                 return ~{6'h0, b[5:0]};
    endfunction

    int checks = 0, fails = 0;
    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: n = clock edges since reset release; step k acts at edge (k+1)*DIV of each
    // period; the scan reflects the pad state at its start and is committed at edge 8*DIV.
    int          n = 0;
    logic [11:0] e_joy [2];
    logic        e_six [2];
    logic        e_p7, e_upd;
    int          s_typ [2];
    logic [11:0] s_btn [2];

    task automatic model_step();
        int t, s;
        if (!rst_n) begin
            n = 0; e_p7 = 1'b1; e_upd = 1'b0;
            for (int i = 0; i < 2; i++) begin e_joy[i] = 12'hFFF; e_six[i] = 1'b0; end
        end else begin
            n = n + 1;
            t = n / DIV;
            if (t == 0) e_p7 = 1'b1;
            else begin
                s = (t - 1) % 256;
                e_p7 = (s < 8) ? (s % 2 == 1) : 1'b1;
            end
            if (n % P == 2 * DIV)
                for (int i = 0; i < 2; i++) begin s_typ[i] = typ[i]; s_btn[i] = btn[i]; end
            e_upd = (n >= 8 * DIV) && ((n - 8 * DIV) % P == 0);
            if (e_upd)
                for (int i = 0; i < 2; i++) begin
                    e_joy[i] = exp_word(s_typ[i], s_btn[i]);
                    e_six[i] = (s_typ[i] == T_MD6);
                end
        end
        chk("p7", 32'(p7), 32'(e_p7));
        chk("upd", 32'(upd), 32'(e_upd));
        chk("joy1", 32'(joy1), 32'(e_joy[0]));
        chk("joy2", 32'(joy2), 32'(e_joy[1]));
        chk("six1", 32'(six1), 32'(e_six[0]));
        chk("six2", 32'(six2), 32'(e_six[1]));
    endtask

    initial forever begin
        @(negedge clk);
        model_step();
    end

    task automatic wait_phase(int ph);
        bit hit = 1'b0;
        for (int i = 0; i < P + 2 && !hit; i++) begin
            @(negedge clk); #1;
            if (n % P == ph) hit = 1'b1;
        end
        if (!hit) chk("wait_phase_timeout", 32'(ph), 32'hFFFF_FFFF);
    endtask

    task automatic wait_upd(output int cyc);
        bit hit = 1'b0;
        cyc = 0;
        for (int i = 0; i < 2 * P + 8 * DIV && !hit; i++) begin
            @(negedge clk);
            cyc++;
            if (upd) hit = 1'b1;
        end
        if (!hit) chk("wait_upd_timeout", 32'(cyc), 32'hFFFF_FFFF);
    endtask

    function automatic logic [11:0] rand_btn();
        logic [11:0] b = 12'($urandom);
        if (b[0] && b[1]) b[1] = 1'b0;   // no physical pad presses Up and Down together
        if (b[2] && b[3]) b[3] = 1'b0;
        return b;
    endfunction

    initial begin
        int cyc;
        typ[0] = T_MD3; typ[1] = T_MD3; btn[0] = '0; btn[1] = '0;
        raw_mode = 1'b1; raw[0] = '0; raw[1] = '0;
        #1 rst_n = 1'b0;
        repeat (20) begin
            @(negedge clk); #1;
            raw[0] = 6'($urandom); raw[1] = 6'($urandom);
        end

        // 3-button pad with Up+B on port 1, idle pad on port 2.
        raw_mode = 1'b0;
        btn[0] = 12'h011;
        @(negedge clk); #1 rst_n = 1'b1;
        wait_upd(cyc);
        chk("first_upd_latency", 32'(cyc), 32'(8 * DIV));
        chk("md3_up_b_joy1", 32'(joy1), 32'hFEE);
        chk("md3_six1", 32'(six1), 32'h0);
        chk("idle_joy2", 32'(joy2), 32'hFFF);

        // SMS pad with button 1 on port 1, 6-button pad with X on port 2; pin the select waveform.
        wait_phase(20 * DIV);
        typ[0] = T_SMS; btn[0] = 12'h010;
        typ[1] = T_MD6; btn[1] = 12'h400;
        for (int k = 0; k < 8; k++) begin
            wait_phase((k + 1) * DIV + 1);
            chk("p7_seq", 32'(p7), 32'(k % 2));
        end
        chk("sms_joy1", 32'(joy1), 32'hFEF);
        chk("sms_six1", 32'(six1), 32'h0);
        chk("md6_x_joy2", 32'(joy2), 32'hBFF);
        chk("md6_six2", 32'(six2), 32'h1);
        wait_phase(100 * DIV);
        chk("p7_idle", 32'(p7), 32'h1);

        // Random pad types and buttons, changed during idle time.
        for (int r = 0; r < 12; r++) begin
            wait_phase(20 * DIV);
            for (int i = 0; i < 2; i++) begin
                typ[i] = int'($urandom_range(0, 2));
                btn[i] = rand_btn();
            end
        end

        // A change after the scan has sampled B shows only at the following commit.
        wait_phase(20 * DIV);
        typ[0] = T_MD3; btn[0] = 12'h000; typ[1] = T_MD3; btn[1] = 12'h000;
        wait_phase(20 * DIV);
        wait_phase(5 * DIV);
        btn[0] = 12'h010;
        wait_phase(8 * DIV + 1);
        chk("midscan_old", 32'(joy1), 32'hFFF);
        wait_phase(8 * DIV + 1);
        chk("midscan_new", 32'(joy1), 32'hFEF);

        // Reset during step 4 aborts the scan immediately.
        wait_phase(20 * DIV);
        btn[0] = 12'h011; btn[1] = 12'h0C0;
        wait_phase(5 * DIV + 1);
        rst_n = 1'b0;
        #1;
        chk("rst_joy1", 32'(joy1), 32'hFFF);
        chk("rst_joy2", 32'(joy2), 32'hFFF);
        chk("rst_p7", 32'(p7), 32'h1);
        chk("rst_upd", 32'(upd), 32'h0);
        chk("rst_six", 32'({six1, six2}), 32'h0);
        repeat (20 * DIV) @(negedge clk);
        #1 rst_n = 1'b1;
        wait_upd(cyc);
        chk("rst_release_latency", 32'(cyc), 32'(8 * DIV));
        chk("after_rst_joy1", 32'(joy1), 32'hFEE);
        chk("after_rst_joy2", 32'(joy2), 32'hF3F);

        // Free-run period and pulse width.
        wait_upd(cyc);
        chk("upd_period", 32'(cyc), 32'(P));
        @(negedge clk);
        chk("upd_width", 32'(upd), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/joy_sega6_reader.md
JOY_SEGA6_READER -- requirements
Module: joy_sega6_reader

Interface
REQ-001 SHALL have parameter DIV, default 704, system-clock cycles per protocol step (about 64 us at 11 MHz); legal range 4..65535.
REQ-002 SHALL have port clk_i  input  1  system clock (clk_sys domain); single clock for the block.
REQ-003 SHALL have port res_n_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports joy1_up_i, joy1_down_i, joy1_left_i, joy1_right_i, joy1_p6_i, joy1_p9_i  input  1 each  DB9 port 1 pins, active-low, asynchronous.
REQ-005 SHALL have ports joy2_up_i, joy2_down_i, joy2_left_i, joy2_right_i, joy2_p6_i, joy2_p9_i  input  1 each  DB9 port 2 pins, same meaning.
REQ-006 SHALL have port joyX_p7_o  output  1  shared select line (pin 7) to both ports.
REQ-007 SHALL have ports joy1_o, joy2_o  output  12 each  decoded buttons, active-low, bit order [11:0] = M X Y Z S A C B R L D U.
REQ-008 SHALL have ports six1_o, six2_o  output  1 each  high when the last scan detected a 6-button pad.
REQ-009 SHALL have port upd_o  output  1  one-clock pulse when joy*_o/six*_o are refreshed.

Function
REQ-010 SHALL pass all twelve pad inputs through a 2-flop synchronizer before any use.
REQ-011 SHALL run a prescaler counting 0..DIV-1 and issue a one-clock tick on terminal count; the tick advances the protocol.
REQ-012 SHALL keep an 8-bit step counter s; on each tick, perform the action for the current s, then s <= s+1, wrapping 255 -> 0 (scan period 256*DIV clocks).
REQ-013 Step 0: p7 <= 0.
REQ-014 Step 1: p7 <= 1.
REQ-015 Step 2: shadow[5:0] <= {p9,p6,R,L,D,U} (select high: C,B,dirs); shadow six flags <= 0; p7 <= 0.
REQ-016 Step 3: per port, if L=0 and R=0, shadow[7:6] <= {p9,p6} (Start,A); otherwise shadow[7:6] <= 2'b11 (Master System pad); p7 <= 1.
REQ-017 Step 4: p7 <= 0.
REQ-018 Step 5: per port, if U, D, L and R are all 0, shadow six flag <= 1; p7 <= 1.
REQ-019 Step 6: per port, if shadow six flag is 1, shadow[11:8] <= {R,L,D,U} (Mode,X,Y,Z); otherwise shadow[11:8] <= 4'hF; p7 <= 0.
REQ-020 Step 7: p7 <= 1; copy both shadows and six flags to joy*_o/six*_o in the same clock; assert upd_o for exactly that clock.
REQ-021 Steps 8..255: p7 held 1; no sampling; outputs hold; this idle time lets 6-button pads reset their internal counter.
REQ-022 Sampling SHALL use synchronized values present in the tick clock; select changes made on one tick are sampled no earlier than the next tick (DIV >= 4 guarantees settling through the synchronizer).
REQ-023 Port 1 and port 2 SHALL be decoded independently from the same select waveform; a mixed pad type on the two ports is legal.
REQ-024 joy*_o SHALL change only on the upd_o clock; no partial frame is ever visible.

Reset
REQ-025 While res_n_i=0, all registers SHALL take reset values immediately: prescaler 0, s=0, joyX_p7_o=1, joy1_o=joy2_o=12'hFFF, shadows 12'hFFF, six*_o=0, upd_o=0, synchronizer flops 1.
REQ-026 Reset mid-scan SHALL abort the scan without committing; after release, the first tick comes DIV clocks later and the first upd_o comes 8*DIV clocks after release.

Verification
REQ-027 Reset: hold res_n_i=0 with random pad inputs -> joy*_o=12'hFFF, six*_o=0, p7=1, upd_o=0 throughout.
REQ-028 3-button MD pad model on port 1, Up+B pressed, DIV=4 -> at first upd_o joy1_o=12'hFEE, six1_o=0; port 2 idle -> joy2_o=12'hFFF.
REQ-029 6-button pad model on port 2, only X pressed -> joy2_o=12'hBFF, six2_o=1; p7 sequence 0,1,0,1,0,1,0,1 on ticks 0..7, then 1 until wrap.
REQ-030 Master System pad on port 1 (L/R never low with select low), button 1 (p6) held -> joy1_o=12'hFEF, six1_o=0.
REQ-031 Assert reset during step 4 with pad pressed -> outputs return to reset values in the same cycle, no upd_o; after release, upd_o exactly 8*DIV clocks later.
REQ-032 Free run, DIV=4 -> upd_o pulses exactly every 1024 clocks, one clock wide; change pad state mid-scan -> new value appears only at the next-but-one commit if the change falls after its sampling step.
